frame_buffer_pp: RTL and testbench

- Parametrised double-buffered (ping-pong) frame store. Generalises the single-bank 320x240 RGB565 buffer to configurable pixel width and resolution.
- Writer side takes a streaming pixel interface with start-of-frame and auto-incrementing address. It fills the write bank and never tears the frame being read.
- Reader side (HPS bridge or arm-vision logic) reads a stable completed frame with 1-cycle latency. It releases the frame to trigger a bank swap.
- Sits between the camera capture path, already synchronised into clk, and the vision/HPS consumers.

---
 rtl/fb_pkg.sv | 20 ++
 rtl/frame_buffer_pp_if.sv | 33 +++
 rtl/fb_dpram.sv | 31 +++
 rtl/frame_buffer_pp.sv | 170 +++++++++++++++++
 tb/tb_frame_buffer_pp.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/fb_pkg.sv
// Shared types and defaults for the ping-pong frame buffer.
package fb_pkg;

  localparam int unsigned DEF_PIX_W = 16;
  localparam int unsigned DEF_H_RES = 320;
  localparam int unsigned DEF_V_RES = 240;
  localparam int unsigned CNT_W     = 16;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    HOLD,
    DROP
  } wr_state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/frame_buffer_pp_if.sv
// Pixel stream, reader and status bundle of the ping-pong frame buffer.
interface frame_buffer_pp_if
  import fb_pkg::*;
#(
  parameter int unsigned PIX_W = DEF_PIX_W,
  parameter int unsigned AW    = 17
);

  logic             wr_valid;
  logic             wr_sof;
  logic [PIX_W-1:0] wr_data;
  logic             rd_req;
  logic [AW-1:0]    rd_addr;
  logic [PIX_W-1:0] rd_data;
  logic             rd_valid;
  logic             rd_release;
  logic             frame_avail;
  logic             frame_pending;
  logic [CNT_W-1:0] frame_cnt;
  logic [CNT_W-1:0] drop_cnt;
  logic             sof_err;

  modport master (
    output wr_valid, wr_sof, wr_data, rd_req, rd_addr, rd_release,
    input  rd_data, rd_valid, frame_avail, frame_pending, frame_cnt, drop_cnt, sof_err
  );

  modport slave (
    input  wr_valid, wr_sof, wr_data, rd_req, rd_addr, rd_release,
    output rd_data, rd_valid, frame_avail, frame_pending, frame_cnt, drop_cnt, sof_err
  );

endinterface

// File: rtl/fb_dpram.sv
// Simple dual-port RAM: one write port, one registered read port, no reset.
module fb_dpram #(
  parameter int unsigned PIX_W = 16,
  parameter int unsigned DEPTH = 256,
  localparam int unsigned AddrW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [PIX_W-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [PIX_W-1:0] rdata_o
);

  logic [PIX_W-1:0] mem_q [DEPTH];
  logic [PIX_W-1:0] rdata_q;

  // Read-before-write ordering: a same-address read returns the old word.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/frame_buffer_pp.sv
// Double-buffered frame store: writer fills one bank while the reader holds
// the other; a reader release swaps banks once a completed frame is waiting.
module frame_buffer_pp
  import fb_pkg::*;
#(
  parameter int unsigned PIX_W = DEF_PIX_W,
  parameter int unsigned H_RES = DEF_H_RES,
  parameter int unsigned V_RES = DEF_V_RES
) (
  input logic              clk,
  input logic              rst,
  frame_buffer_pp_if.slave fb_io
);

  localparam int unsigned NPIX  = H_RES * V_RES;
  localparam int unsigned AW    = $clog2(NPIX);
  localparam int unsigned DEPTH = 2 * (2 ** AW);

  localparam logic [AW-1:0] LastIdx = AW'(NPIX - 1);
  localparam logic [AW-1:0] ZeroIdx = '0;
  localparam logic [AW-1:0] OneIdx  = AW'(1);

  wr_state_t        state_q, state_d;
  logic             wbank_q, wbank_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic             pending_q, pending_d;
  logic             avail_q, avail_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic             sof_err_q, sof_err_d;
  logic             rd_valid_q;
  logic             rd_seen_q;

  logic             sof;
  logic             pix;
  logic             complete;
  logic             swap;
  logic             ram_we;
  logic [AW:0]      ram_waddr;
  logic [PIX_W-1:0] ram_rdata;

  always_comb begin
    sof      = fb_io.wr_valid & fb_io.wr_sof;
    pix      = fb_io.wr_valid & ~fb_io.wr_sof;
    complete = (state_q == WRITE) & pix & (wr_ptr_q == LastIdx);
    swap     = fb_io.rd_release & (pending_q | complete);

    state_d     = state_q;
    wbank_d     = wbank_q;
    wr_ptr_d    = wr_ptr_q;
    pending_d   = pending_q;
    avail_d     = avail_q;
    frame_cnt_d = frame_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    sof_err_d   = sof_err_q;
    ram_we      = 1'b0;
    ram_waddr   = {wbank_q, wr_ptr_q};

    unique case (state_q)
      IDLE: begin
        if (sof) begin
          ram_we    = 1'b1;
          ram_waddr = {wbank_q, ZeroIdx};
          wr_ptr_d  = OneIdx;
          state_d   = WRITE;
        end
      end
      WRITE: begin
        if (sof) begin
          // Short frame: restart from index 0 in the same bank.
          sof_err_d = 1'b1;
          ram_we    = 1'b1;
          ram_waddr = {wbank_q, ZeroIdx};
          wr_ptr_d  = OneIdx;
        end else if (pix) begin
          ram_we    = 1'b1;
          ram_waddr = {wbank_q, wr_ptr_q};
          if (wr_ptr_q == LastIdx) begin
            wr_ptr_d  = ZeroIdx;
            pending_d = 1'b1;
            state_d   = HOLD;
          end else begin
            wr_ptr_d = wr_ptr_q + OneIdx;
          end
        end
      end
      HOLD: begin
        if (sof) begin
          drop_cnt_d = sat_inc(drop_cnt_q);
          state_d    = DROP;
        end
      end
      DROP: begin
        if (sof) begin
          drop_cnt_d = sat_inc(drop_cnt_q);
        end
      end
      default: state_d = IDLE;
    endcase

    // Swap wins over the writer; a SOF in this cycle opens the fresh bank
    // instead of counting as a drop.
    if (swap) begin
      wbank_d     = ~wbank_q;
      pending_d   = 1'b0;
      avail_d     = 1'b1;
      frame_cnt_d = frame_cnt_q + CNT_W'(1);
      drop_cnt_d  = drop_cnt_q;
      if (sof) begin
        ram_we    = 1'b1;
        ram_waddr = {~wbank_q, ZeroIdx};
        wr_ptr_d  = OneIdx;
        state_d   = WRITE;
      end else begin
        wr_ptr_d = ZeroIdx;
        state_d  = IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wbank_q     <= 1'b0;
      wr_ptr_q    <= '0;
      pending_q   <= 1'b0;
      avail_q     <= 1'b0;
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
      sof_err_q   <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_seen_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wbank_q     <= wbank_d;
      wr_ptr_q    <= wr_ptr_d;
      pending_q   <= pending_d;
      avail_q     <= avail_d;
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      sof_err_q   <= sof_err_d;
      rd_valid_q  <= fb_io.rd_req;
      rd_seen_q   <= rd_seen_q | fb_io.rd_req;
    end
  end

  // Reader bank is always the complement of the writer bank.
  fb_dpram #(
    .PIX_W(PIX_W),
    .DEPTH(DEPTH)
  ) u_ram (
    .clk_i  (clk),
    .we_i   (ram_we),
    .waddr_i(ram_waddr),
    .wdata_i(fb_io.wr_data),
    .re_i   (fb_io.rd_req),
    .raddr_i({~wbank_q, fb_io.rd_addr}),
    .rdata_o(ram_rdata)
  );

  // The RAM output register has no reset, so mask it until the first read.
  assign fb_io.rd_data       = rd_seen_q ? ram_rdata : '0;
  assign fb_io.rd_valid      = rd_valid_q;
  assign fb_io.frame_avail   = avail_q;
  assign fb_io.frame_pending = pending_q;
  assign fb_io.frame_cnt     = frame_cnt_q;
  assign fb_io.drop_cnt      = drop_cnt_q;
  assign fb_io.sof_err       = sof_err_q;

endmodule

// File: tb/tb_frame_buffer_pp.sv
// Scoreboard bench for frame_buffer_pp with a 4x2 frame.
module tb_frame_buffer_pp;

  localparam int unsigned PixW = 16;
  localparam int unsigned HRes = 4;
  localparam int unsigned VRes = 2;
  localparam int unsigned Aw   = 3;

  typedef struct {
    logic [15:0] data;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks  = 0;
  int   errors  = 0;
  int   cyc_cnt = 0;
  exp_t sb_q[$];
  exp_t mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  frame_buffer_pp_if #(.PIX_W(PixW), .AW(Aw)) fb_if ();

  frame_buffer_pp #(
    .PIX_W(PixW),
    .H_RES(HRes),
    .V_RES(VRes)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .fb_io(fb_if)
  );

  // Read-data monitor: each expected entry is due on a specific cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (sb_q.size() != 0 && sb_q[0].cyc <= cyc_cnt) begin
        mon_e = sb_q.pop_front();
        checks++;
        if (!fb_if.rd_valid || fb_if.rd_data !== mon_e.data || mon_e.cyc != cyc_cnt) begin
          errors++;
          $display("FAIL rd_data cyc %0d: valid %0b data %h, expected valid 1 data %h at cyc %0d",
                   cyc_cnt, fb_if.rd_valid, fb_if.rd_data, mon_e.data, mon_e.cyc);
        end
      end else if (fb_if.rd_valid) begin
        checks++;
        errors++;
        $display("FAIL rd_valid spurious cyc %0d: got 1 expected 0", cyc_cnt);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic status(input string tag, input logic avail, input logic pend,
                        input int fcnt, input int dcnt, input logic serr);
    chk({tag, " frame_avail"}, 32'(fb_if.frame_avail), 32'(avail));
    chk({tag, " frame_pending"}, 32'(fb_if.frame_pending), 32'(pend));
    chk({tag, " frame_cnt"}, 32'(fb_if.frame_cnt), fcnt);
    chk({tag, " drop_cnt"}, 32'(fb_if.drop_cnt), dcnt);
    chk({tag, " sof_err"}, 32'(fb_if.sof_err), 32'(serr));
  endtask

  task automatic pix(input logic [15:0] d, input logic sof);
    fb_if.wr_valid = 1'b1;
    fb_if.wr_sof   = sof;
    fb_if.wr_data  = d;
    tick();
    fb_if.wr_valid = 1'b0;
    fb_if.wr_sof   = 1'b0;
  endtask

  task automatic frame(input logic [15:0] base, input int n);
    for (int i = 0; i < n; i++) pix(16'(base + i), i == 0);
  endtask

  task automatic rd(input logic [2:0] a, input logic [15:0] exp);
    fb_if.rd_req  = 1'b1;
    fb_if.rd_addr = a;
    sb_q.push_back('{exp, cyc_cnt + 1});
    tick();
    fb_if.rd_req = 1'b0;
  endtask

  task automatic rd_frame(input logic [15:0] base);
    for (int i = 0; i < 8; i++) rd(3'(i), 16'(base + i));
  endtask

  task automatic release_frame();
    fb_if.rd_release = 1'b1;
    tick();
    fb_if.rd_release = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    fb_if.wr_valid   = 1'b0;
    fb_if.wr_sof     = 1'b0;
    fb_if.wr_data    = '0;
    fb_if.rd_req     = 1'b0;
    fb_if.rd_addr    = '0;
    fb_if.rd_release = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    status("reset", 1'b0, 1'b0, 0, 0, 1'b0);
    chk("reset rd_valid", 32'(fb_if.rd_valid), 0);
    chk("reset rd_data", 32'(fb_if.rd_data), 0);
    rst = 1'b0;
    tick();

    // 1: basic frame, release, read back.
    frame(16'h0100, 8);
    chk("t1 pending", 32'(fb_if.frame_pending), 1);
    release_frame();
    status("t1", 1'b1, 1'b0, 1, 0, 1'b0);
    rd_frame(16'h0100);

    // 2: completed frame held, next SOF dropped, release shows held frame.
    frame(16'h0200, 8);
    chk("t2 pending", 32'(fb_if.frame_pending), 1);
    pix(16'h0300, 1'b1);
    pix(16'h0301, 1'b0);
    pix(16'h0302, 1'b0);
    chk("t2 drop_cnt", 32'(fb_if.drop_cnt), 1);
    rd(3'd0, 16'h0100);
    release_frame();
    status("t2", 1'b1, 1'b0, 2, 1, 1'b0);
    rd_frame(16'h0200);
    frame(16'h0400, 8);
    chk("t2 f4 pending", 32'(fb_if.frame_pending), 1);
    release_frame();
    chk("t2 f4 frame_cnt", 32'(fb_if.frame_cnt), 3);
    rd(3'd0, 16'h0400);
    rd(3'd7, 16'h0407);

    // 3: SOF mid-frame restarts the frame.
    frame(16'h0500, 5);
    chk("t3 sof_err before", 32'(fb_if.sof_err), 0);
    frame(16'h0600, 8);
    chk("t3 sof_err", 32'(fb_if.sof_err), 1);
    chk("t3 pending", 32'(fb_if.frame_pending), 1);
    release_frame();
    chk("t3 frame_cnt", 32'(fb_if.frame_cnt), 4);
    rd_frame(16'h0600);

    // 4: last pixel, release and read in the same cycle.
    frame(16'h0700, 7);
    fb_if.wr_valid   = 1'b1;
    fb_if.wr_sof     = 1'b0;
    fb_if.wr_data    = 16'h0707;
    fb_if.rd_release = 1'b1;
    fb_if.rd_req     = 1'b1;
    fb_if.rd_addr    = 3'd2;
    sb_q.push_back('{16'h0602, cyc_cnt + 1});
    tick();
    fb_if.wr_valid   = 1'b0;
    fb_if.rd_release = 1'b0;
    fb_if.rd_req     = 1'b0;
    status("t4", 1'b1, 1'b0, 5, 1, 1'b1);
    rd_frame(16'h0700);

    // 5: release with nothing pending is ignored.
    release_frame();
    status("t5", 1'b1, 1'b0, 5, 1, 1'b1);
    rd(3'd3, 16'h0703);
    rd(3'd6, 16'h0706);

    // 6: asynchronous reset mid-frame.
    pix(16'h0800, 1'b1);
    pix(16'h0801, 1'b0);
    pix(16'h0802, 1'b0);
    fb_if.wr_valid = 1'b1;
    fb_if.wr_data  = 16'h0803;
    #2 rst = 1'b1;
    #1;
    status("t6 reset", 1'b0, 1'b0, 0, 0, 1'b0);
    chk("t6 rd_valid", 32'(fb_if.rd_valid), 0);
    chk("t6 rd_data", 32'(fb_if.rd_data), 0);
    fb_if.wr_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    frame(16'h0900, 8);
    chk("t6 pending", 32'(fb_if.frame_pending), 1);
    release_frame();
    status("t6", 1'b1, 1'b0, 1, 0, 1'b0);
    rd_frame(16'h0900);

    repeat (3) tick();
    chk("scoreboard drained", 32'(sb_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
